// File: rtl/irda_multi_rx_fifo.sv
// irda_multi_rx_fifo: routes decoded IR frames by customer code into per-channel
// FIFOs and exposes them on the I/O bus through a pop-on-read DATA register.
module irda_multi_rx_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0600,
    parameter int          NCH       = 4,
    parameter int          DEPTH     = 8
) (
    input  logic        iCLK,
    input  logic        Reset,
    input  logic        iFrameValid,
    input  logic [31:0] iFrame,
    input  logic        wReadEnable,
    input  logic        wWriteEnable,
    input  logic [3:0]  wByteEnable,
    input  logic [31:0] wAddress,
    input  logic [31:0] wWriteData,
    output logic [31:0] wReadData,
    output logic        oIRQ
);
    localparam int          CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] WIN = 32'h10 + 32'(4 * NCH);

    logic             enable, catch_all, irq_en;
    logic [2:0]       sel;
    logic [15:0]      ids    [NCH];
    logic [31:0]      mem    [NCH][DEPTH];
    logic [AW-1:0]    rd_ptr [NCH];
    logic [AW-1:0]    wr_ptr [NCH];
    logic [CW-1:0]    cnt    [NCH];
    logic [NCH-1:0]   ovf, ovf_next, nonempty, push_vec, pop_vec;
    logic [7:0]       drop;
    logic             data_rd_q;

    logic [31:0]      offset, rdata;
    logic             in_win, wr, data_rd, sel_ok, flush;
    logic [3:0]       word;
    logic             id_hit;
    logic [CHW-1:0]   id_idx, sel_idx, tgt;
    logic             hit, frame_in, route_ok, tgt_full, pop_tgt;
    logic             pop_req, do_pop, do_push, do_ovf, do_drop;
    logic             unused_bits;

    assign unused_bits = ^{offset[31:6], offset[1:0], wWriteData, wByteEnable[2]};

    // Address decode, read-edge detection and frame routing decisions
    always_comb begin
        offset   = wAddress - BASE_ADDR;
        in_win   = (wAddress >= BASE_ADDR) && (offset < WIN);
        word     = offset[5:2];
        id_hit   = (word >= 4'd4);
        id_idx   = CHW'(word - 4'd4);
        wr       = wWriteEnable && in_win;
        data_rd  = wReadEnable && in_win && (word == 4'd2);
        sel_ok   = (32'(sel) < 32'(NCH));
        sel_idx  = sel[CHW-1:0];
        flush    = wr && (word == 4'd0) && wByteEnable[3] && wWriteData[31];
        // Only the first cycle of a DATA access pops, and never from an empty FIFO
        pop_req  = data_rd && !data_rd_q && sel_ok && (cnt[sel_idx] != '0);
        do_pop   = pop_req && !flush;

        // Descending scan leaves the lowest matching channel in tgt
        hit = 1'b0;
        tgt = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ids[k] == iFrame[15:0]) begin
                hit = 1'b1;
                tgt = CHW'(k);
            end
        end

        frame_in = enable && iFrameValid && !flush;
        route_ok = frame_in && (hit || catch_all);
        tgt_full = (cnt[tgt] == CW'(DEPTH));
        pop_tgt  = do_pop && (sel_idx == tgt);
        // A full FIFO still accepts a push when its head leaves in the same cycle
        do_push  = route_ok && (!tgt_full || pop_tgt);
        do_ovf   = route_ok && tgt_full && !pop_tgt;
        do_drop  = frame_in && !hit && !catch_all;

        for (int k = 0; k < NCH; k++) begin
            push_vec[k] = do_push && (tgt == CHW'(k));
            pop_vec[k]  = do_pop && (sel_idx == CHW'(k));
            nonempty[k] = (cnt[k] != '0);
        end

        // Clearing first lets a same-cycle overflow win over the W1C
        ovf_next = ovf;
        if (wr && (word == 4'd1) && wByteEnable[1])
            ovf_next = ovf & ~wWriteData[8 +: NCH];
        if (do_ovf)
            ovf_next[tgt] = 1'b1;
    end

    // Control registers, FIFO pointers/counts, drop counter and interrupt
    always_ff @(posedge iCLK) begin
        if (Reset) begin
            enable    <= 1'b0;
            catch_all <= 1'b0;
            irq_en    <= 1'b0;
            sel       <= '0;
            ovf       <= '0;
            drop      <= '0;
            data_rd_q <= 1'b0;
            oIRQ      <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                ids[k]    <= '0;
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            data_rd_q <= data_rd;
            oIRQ      <= irq_en & enable & (|nonempty);
            ovf       <= ovf_next;

            if (wr && (word == 4'd0) && wByteEnable[0]) begin
                enable    <= wWriteData[0];
                catch_all <= wWriteData[1];
                irq_en    <= wWriteData[2];
                sel       <= wWriteData[6:4];
            end

            if (wr && id_hit) begin
                if (wByteEnable[0]) ids[id_idx][7:0]  <= wWriteData[7:0];
                if (wByteEnable[1]) ids[id_idx][15:8] <= wWriteData[15:8];
            end

            if (wr && (word == 4'd3))
                drop <= '0;
            else if (do_drop && (drop != 8'hFF))
                drop <= drop + 8'd1;

            for (int k = 0; k < NCH; k++) begin
                if (flush) begin
                    rd_ptr[k] <= '0;
                    wr_ptr[k] <= '0;
                    cnt[k]    <= '0;
                end else begin
                    if (push_vec[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
                    if (pop_vec[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
                    if (push_vec[k] && !pop_vec[k])
                        cnt[k] <= cnt[k] + CW'(1);
                    else if (!push_vec[k] && pop_vec[k])
                        cnt[k] <= cnt[k] - CW'(1);
                end
            end
        end
    end

    // FIFO storage; contents need no reset since counts gate every read
    always_ff @(posedge iCLK) begin
        if (do_push)
            mem[tgt][wr_ptr[tgt]] <= iFrame;
    end

    // Combinational register read mux, tri-stated outside an in-window read
    always_comb begin
        rdata = '0;
        case (word)
            4'd0: rdata = {25'd0, sel, 1'b0, irq_en, catch_all, enable};
            4'd1: begin
                rdata[NCH-1:0]  = nonempty;
                rdata[8 +: NCH] = ovf;
                if (sel_ok)
                    rdata[20:16] = 5'(cnt[sel_idx]);
            end
            4'd2: begin
                if (sel_ok && (cnt[sel_idx] != '0))
                    rdata = mem[sel_idx][rd_ptr[sel_idx]];
            end
            4'd3: rdata = {24'd0, drop};
            default: begin
                if (id_hit)
                    rdata = {16'd0, ids[id_idx]};
            end
        endcase
        wReadData = (wReadEnable && in_win) ? rdata : 32'hzzzzzzzz;
    end

endmodule

// File: tb/tb_irda_multi_rx_fifo.sv
// Bench for irda_multi_rx_fifo: directed scenarios followed by random bus and
// frame traffic, all checked against a queue-based model of the register map.
module tb_irda_multi_rx_fifo;
    localparam int          NCH   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hFFFF0600;
    localparam logic [31:0] A_CTRL = BASE, A_STAT = BASE + 32'h4, A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_DROP = BASE + 32'hC, A_ID0 = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        iFrameValid = 1'b0;
    logic [31:0] iFrame = '0;
    logic        wReadEnable = 1'b0;
    logic        wWriteEnable = 1'b0;
    logic [3:0]  wByteEnable = '0;
    logic [31:0] wAddress = '0;
    logic [31:0] wWriteData = '0;
    logic [31:0] wReadData;
    logic        oIRQ;

    always #5 clk = ~clk;

    irda_multi_rx_fifo #(.BASE_ADDR(BASE), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .iCLK(clk), .Reset(Reset), .iFrameValid(iFrameValid), .iFrame(iFrame),
        .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable), .wByteEnable(wByteEnable),
        .wAddress(wAddress), .wWriteData(wWriteData), .wReadData(wReadData), .oIRQ(oIRQ)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0]    mq [NCH][$];
    logic           m_en, m_catch, m_irqen, m_irq, m_prev;
    logic [2:0]     m_sel;
    logic [15:0]    m_id [NCH];
    logic [NCH-1:0] m_ovf;
    int             m_drop;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            mq[k].delete();
            m_id[k] = '0;
        end
        m_en = 0; m_catch = 0; m_irqen = 0; m_irq = 0; m_prev = 0;
        m_sel = '0; m_ovf = '0; m_drop = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off, r;
        int w;
        off = a - BASE;
        if (a < BASE || off >= 32'h10 + 32'(4 * NCH)) return 32'hzzzzzzzz;
        w = int'(off >> 2);
        r = '0;
        case (w)
            0: r = {25'd0, m_sel, 1'b0, m_irqen, m_catch, m_en};
            1: begin
                for (int k = 0; k < NCH; k++) begin
                    r[k]     = (mq[k].size() > 0);
                    r[8 + k] = m_ovf[k];
                end
                if (m_sel < NCH) r[20:16] = 5'(mq[m_sel].size());
            end
            2: if (m_sel < NCH && mq[m_sel].size() > 0) r = mq[m_sel][0];
            3: r = 32'(m_drop);
            default: r = {16'd0, m_id[w - 4]};
        endcase
        return r;
    endfunction

    // Apply one clock edge to the model, using the inputs currently driven
    task automatic model_step();
        logic [31:0] off;
        int w, tgt;
        bit inwin, drd, pop, wrw, flush, any;
        off   = wAddress - BASE;
        inwin = (wAddress >= BASE) && (off < 32'h10 + 32'(4 * NCH));
        w     = int'(off >> 2);
        drd   = wReadEnable && inwin && (w == 2);
        pop   = drd && !m_prev && (m_sel < NCH) && (mq[m_sel].size() > 0);
        wrw   = wWriteEnable && inwin;
        flush = wrw && (w == 0) && wByteEnable[3] && wWriteData[31];
        any = 0;
        for (int k = 0; k < NCH; k++) if (mq[k].size() > 0) any = 1;
        m_irq  = m_irqen && m_en && any;
        m_prev = drd;
        if (wrw && w == 1 && wByteEnable[1]) m_ovf = m_ovf & ~wWriteData[8 +: NCH];
        if (flush) begin
            for (int k = 0; k < NCH; k++) mq[k].delete();
        end else begin
            if (pop) void'(mq[m_sel].pop_front());
            if (m_en && iFrameValid) begin
                tgt = -1;
                for (int k = 0; k < NCH; k++)
                    if (tgt < 0 && m_id[k] == iFrame[15:0]) tgt = k;
                if (tgt < 0 && m_catch) tgt = 0;
                if (tgt < 0) begin
                    if (m_drop < 255) m_drop++;
                end else if (mq[tgt].size() == DEPTH) begin
                    m_ovf[tgt] = 1'b1;
                end else begin
                    mq[tgt].push_back(iFrame);
                end
            end
        end
        if (wrw) begin
            if (w == 0 && wByteEnable[0]) begin
                m_en = wWriteData[0]; m_catch = wWriteData[1];
                m_irqen = wWriteData[2]; m_sel = wWriteData[6:4];
            end
            if (w == 3) m_drop = 0;
            if (w >= 4) begin
                if (wByteEnable[0]) m_id[w - 4][7:0]  = wWriteData[7:0];
                if (wByteEnable[1]) m_id[w - 4][15:8] = wWriteData[15:8];
            end
        end
    endtask

    // One bus/frame cycle: drive, check combinational read, clock, check IRQ
    task automatic cycle(input logic fv, input logic [31:0] fr, input logic re, input logic we,
                         input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
        @(negedge clk);
        Reset = 1'b0;
        iFrameValid = fv; iFrame = fr; wReadEnable = re; wWriteEnable = we;
        wByteEnable = be; wAddress = a; wWriteData = wd;
        #1;
        rd = wReadData;
        chk("rdata", rd, re ? model_read(a) : 32'hzzzzzzzz);
        @(posedge clk);
        model_step();
        #1;
        chk("irq", {31'd0, oIRQ}, {31'd0, m_irq});
    endtask

    task automatic do_reset(input logic with_read);
        @(negedge clk);
        Reset = 1'b1; iFrameValid = 0; wWriteEnable = 0;
        wReadEnable = with_read; wAddress = A_DATA;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_irq", {31'd0, oIRQ}, 32'd0);
    endtask

    logic [31:0] d;

    task automatic idle();
        cycle(0, '0, 0, 0, 4'h0, '0, '0, d);
    endtask
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
        cycle(0, '0, 1, 0, 4'h0, a, '0, r);
        idle();
    endtask
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
        cycle(0, '0, 0, 1, 4'hF, a, v, d);
    endtask
    task automatic frm(input logic [31:0] f);
        cycle(1, f, 0, 0, 4'h0, '0, '0, d);
    endtask

    logic [31:0] saved [16];
    logic [31:0] r;
    logic [15:0] codes [5];

    initial begin
        model_reset();
        do_reset(1'b0);
        bus_rd(A_CTRL, r);   chk("rst_ctrl", r, 32'd0);
        bus_rd(A_STAT, r);   chk("rst_status", r, 32'd0);
        bus_rd(A_ID0, r);    chk("rst_id0", r, 32'd0);
        idle();

        // Basic routing and interrupt
        bus_wr(A_ID0, 32'h0000_7F80);
        bus_wr(A_ID0 + 4, 32'h0000_2C2C);
        bus_wr(A_CTRL, 32'h5);
        frm(32'hE51A7F80);
        cycle(0, '0, 1, 0, 4'h0, A_STAT, '0, r);
        chk("tp1_status", {30'd0, r[1:0]}, 32'd1);
        chk("tp1_irq", {31'd0, oIRQ}, 32'd1);
        idle();
        bus_rd(A_DATA, r);   chk("tp1_data", r, 32'hE51A7F80);
        bus_rd(A_STAT, r);   chk("tp1_empty", {31'd0, r[0]}, 32'd0);

        // Overflow on channel 1
        bus_wr(A_CTRL, 32'h15);
        for (int i = 0; i < 9; i++) begin
            saved[i] = {$urandom_range(0, 65535), 16'h2C2C};
            frm(saved[i]);
        end
        bus_rd(A_STAT, r);
        chk("ovf_count", {27'd0, r[20:16]}, 32'd8);
        chk("ovf_flag", {31'd0, r[9]}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus_rd(A_DATA, r);
            chk("ovf_order", r, saved[i]);
        end
        bus_wr(A_STAT, 32'h200);
        bus_rd(A_STAT, r);   chk("ovf_w1c", {31'd0, r[9]}, 32'd0);

        // Multicycle read pops once
        frm(32'hAAAA2C2C);
        frm(32'hBBBB2C2C);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 4'h0, A_DATA, '0, r);
        idle();
        bus_rd(A_STAT, r);   chk("hold_count", {27'd0, r[20:16]}, 32'd1);
        bus_rd(A_DATA, r);   chk("hold_next", r, 32'hBBBB2C2C);

        // Unmatched frames: drop, then catch-all
        bus_wr(A_CTRL, 32'h5);
        frm(32'hABCD1234);
        bus_rd(A_DROP, r);   chk("drop_cnt", r, 32'd1);
        bus_rd(A_STAT, r);   chk("drop_nofifo", {28'd0, r[3:0]}, 32'd0);
        bus_wr(A_CTRL, 32'h7);
        frm(32'hABCD1234);
        bus_rd(A_STAT, r);   chk("catch_count", {27'd0, r[20:16]}, 32'd1);
        bus_rd(A_DATA, r);   chk("catch_data", r, 32'hABCD1234);

        // Full channel with simultaneous push and pop
        bus_wr(A_CTRL, 32'h15);
        for (int i = 0; i < 8; i++) begin
            saved[i] = {$urandom_range(0, 65535), 16'h2C2C};
            frm(saved[i]);
        end
        cycle(1, 32'h5A5A2C2C, 1, 0, 4'h0, A_DATA, '0, r);
        chk("pp_head", r, saved[0]);
        idle();
        bus_rd(A_STAT, r);
        chk("pp_count", {27'd0, r[20:16]}, 32'd8);
        chk("pp_noovf", {31'd0, r[9]}, 32'd0);
        for (int i = 1; i < 8; i++) bus_rd(A_DATA, r);
        bus_rd(A_DATA, r);   chk("pp_tail", r, 32'h5A5A2C2C);

        // Flush colliding with a frame strobe
        frm(32'h11112C2C);
        frm(32'h22227F80);
        cycle(1, 32'h33337F80, 0, 1, 4'hF, A_CTRL, 32'h8000_0015, d);
        bus_rd(A_STAT, r);   chk("flush_status", r & 32'h001F0F0F, 32'd0);
        bus_rd(A_CTRL, r);   chk("flush_ctrl", r, 32'h15);

        // Reset in the middle of a DATA read
        frm(32'h44442C2C);
        do_reset(1'b1);
        bus_rd(A_STAT, r);   chk("rst_mid_status", r, 32'd0);

        // Randomised traffic
        codes[0] = 16'h7F80; codes[1] = 16'h2C2C; codes[2] = 16'h1234; codes[3] = 16'h0001;
        bus_wr(A_ID0,      32'h0000_7F80);
        bus_wr(A_ID0 + 4,  32'h0000_2C2C);
        bus_wr(A_ID0 + 8,  32'h0000_7F80);
        bus_wr(A_ID0 + 12, 32'h0000_1234);
        bus_wr(A_CTRL, 32'h7);
        for (int n = 0; n < 4000; n++) begin
            logic fv, re, we;
            logic [31:0] fr, a, wd;
            logic [3:0] be;
            int sel_r, w;
            codes[4] = 16'($urandom);
            fv = ($urandom_range(0, 2) == 0);
            fr = {16'($urandom), codes[$urandom_range(0, 4)]};
            sel_r = $urandom_range(0, 99);
            re = 0; we = 0; be = 4'h0; a = '0; wd = '0;
            if (sel_r == 0) begin
                do_reset($urandom_range(0, 1) == 1);
                bus_wr(A_CTRL, 32'h7);
                continue;
            end else if (sel_r < 45) begin
                re = 1;
                w = ($urandom_range(0, 1) == 1) ? 2 : $urandom_range(0, 7);
                a = BASE + 32'(4 * w);
                if (sel_r < 4) a = (sel_r == 1) ? BASE - 4 : BASE + 32'h20;
            end else if (sel_r < 58) begin
                we = 1;
                w = $urandom_range(0, 7);
                a = BASE + 32'(4 * w);
                be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                wd = $urandom;
                if (w == 0) begin
                    wd[31] = ($urandom_range(0, 15) == 0);
                    wd[0]  = ($urandom_range(0, 5) != 0);
                end
                if (w >= 4) wd[15:0] = codes[$urandom_range(0, 3)];
            end
            cycle(fv, fr, re, we, be, a, wd, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
